// File: rtl/pe_noc_interface.sv
// PE <-> NoC leaf network interface.
// TX: PE valid/ready -> 4-phase bundled-data sender into the router.
// RX: 4-phase receiver from the router -> destination filter -> FWFT FIFO -> PE valid/ready.
module pe_noc_interface #(
  parameter int                    WIDTH_packet = 14,
  parameter int                    WIDTH_dest   = 3,
  parameter int                    WIDTH_addr   = 3,
  parameter logic [WIDTH_addr-1:0] NODE_ADDR    = '0,
  parameter int                    RX_DEPTH     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  input  logic [WIDTH_dest-1:0]   tx_dest,
  input  logic [7:0]              tx_payload,
  output logic [WIDTH_packet-1:0] net_out_data,
  output logic                    net_out_req,
  input  logic                    net_out_ack,
  input  logic [WIDTH_packet-1:0] net_in_data,
  input  logic                    net_in_req,
  output logic                    net_in_ack,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic [WIDTH_addr-1:0]   rx_src,
  output logic [7:0]              rx_payload,
  output logic [7:0]              misroute_cnt
);

  localparam int PTR_W   = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = WIDTH_addr + 8;

  typedef enum logic [1:0] {T_IDLE, T_SETUP, T_REQ, T_REL} tx_state_t;
  typedef enum logic {R_IDLE, R_ACK} rx_state_t;

  // ---------------------------------------------------------------- sync
  logic ack_meta_reg, ack_s;
  logic req_meta_reg, req_s;

  // Two-flop synchronizers for the asynchronous handshake inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_meta_reg <= 1'b0;
      ack_s        <= 1'b0;
      req_meta_reg <= 1'b0;
      req_s        <= 1'b0;
    end else begin
      ack_meta_reg <= net_out_ack;
      ack_s        <= ack_meta_reg;
      req_meta_reg <= net_in_req;
      req_s        <= req_meta_reg;
    end
  end

  // ---------------------------------------------------------------- TX
  tx_state_t tx_state_reg, tx_state_next;
  logic      out_req_next;
  logic      tx_accept;

  // TX next-state: data is launched one cycle ahead of req so it is settled at the router
  always_comb begin
    tx_state_next = tx_state_reg;
    out_req_next  = net_out_req;
    tx_accept     = 1'b0;
    case (tx_state_reg)
      T_IDLE: begin
        if (tx_valid && tx_ready) begin
          tx_accept     = 1'b1;
          tx_state_next = T_SETUP;
        end
      end
      T_SETUP: begin
        out_req_next  = 1'b1;
        tx_state_next = T_REQ;
      end
      T_REQ: begin
        if (ack_s) begin
          out_req_next  = 1'b0;
          tx_state_next = T_REL;
        end
      end
      T_REL: begin
        if (!ack_s) tx_state_next = T_IDLE;
      end
      default: begin
        out_req_next  = 1'b0;
        tx_state_next = T_IDLE;
      end
    endcase
  end

  // TX state and registered outputs; tx_ready mirrors "next state is idle"
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_reg <= T_IDLE;
      net_out_req  <= 1'b0;
      net_out_data <= '0;
      tx_ready     <= 1'b0;
    end else begin
      tx_state_reg <= tx_state_next;
      net_out_req  <= out_req_next;
      tx_ready     <= (tx_state_next == T_IDLE);
      if (tx_accept) net_out_data <= {tx_dest, NODE_ADDR, tx_payload};
    end
  end

  // ---------------------------------------------------------------- RX
  rx_state_t               rx_state_reg, rx_state_next;
  logic                    in_ack_next;
  logic                    rx_take;
  logic                    dest_match;
  logic [ENTRY_W-1:0]      rx_entry;
  logic                    fifo_full;
  logic                    push, pop;

  logic [ENTRY_W-1:0]      mem_reg [RX_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]        count_reg, count_next;
  logic [ENTRY_W-1:0]      head_next;

  assign dest_match = (net_in_data[WIDTH_packet-1 -: WIDTH_dest] == NODE_ADDR);
  assign rx_entry   = net_in_data[ENTRY_W-1:0];
  assign fifo_full  = (count_reg == CNT_W'(RX_DEPTH));

  // RX next-state: only take a packet when there is room, otherwise leave req unacked
  always_comb begin
    rx_state_next = rx_state_reg;
    in_ack_next   = net_in_ack;
    rx_take       = 1'b0;
    case (rx_state_reg)
      R_IDLE: begin
        if (req_s && !fifo_full) begin
          rx_take       = 1'b1;
          in_ack_next   = 1'b1;
          rx_state_next = R_ACK;
        end
      end
      R_ACK: begin
        if (!req_s) begin
          in_ack_next   = 1'b0;
          rx_state_next = R_IDLE;
        end
      end
      default: begin
        in_ack_next   = 1'b0;
        rx_state_next = R_IDLE;
      end
    endcase
  end

  assign push = rx_take && dest_match;
  assign pop  = rx_valid && rx_ready;

  // FIFO bookkeeping; head bypasses the array when the pushed word becomes the head
  always_comb begin
    rd_ptr_next = pop ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
    count_next  = count_reg;
    if (push && !pop)      count_next = count_reg + CNT_W'(1);
    else if (!push && pop) count_next = count_reg - CNT_W'(1);
    head_next = (push && (wr_ptr_reg == rd_ptr_next)) ? rx_entry : mem_reg[rd_ptr_next];
  end

  // RX state, handshake, FIFO storage and registered head outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_reg <= R_IDLE;
      net_in_ack   <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      rx_valid     <= 1'b0;
      rx_src       <= '0;
      rx_payload   <= '0;
      for (int i = 0; i < RX_DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      rx_state_reg <= rx_state_next;
      net_in_ack   <= in_ack_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      if (push) begin
        mem_reg[wr_ptr_reg] <= rx_entry;
        wr_ptr_reg          <= wr_ptr_reg + PTR_W'(1);
      end
      rx_valid               <= (count_next != '0);
      {rx_src, rx_payload}   <= head_next;
    end
  end

  // Saturating count of packets dropped for a foreign destination
  always_ff @(posedge clk) begin
    if (rst) begin
      misroute_cnt <= '0;
    end else if (rx_take && !dest_match && (misroute_cnt != 8'hFF)) begin
      misroute_cnt <= misroute_cnt + 8'd1;
    end
  end

endmodule
